// File: rtl/pwm_carrier_pkg.sv
// Shared types for the PWM leg: on/off control, carrier shape and shadow-update selection.
// CARRCOUNT_WIDTH sets the default carrier counter width for every block in the slice.
`ifndef CARRCOUNT_WIDTH
`define CARRCOUNT_WIDTH 16
`endif

package PKG_pwm;

   typedef enum logic {
      PWM_OFF = 1'b0,
      PWM_ON  = 1'b1
   } _pwm_onoff;

   typedef enum logic [1:0] {
      CARR_UP     = 2'd0,
      CARR_DOWN   = 2'd1,
      CARR_UPDOWN = 2'd2
   } _carr_mode;

   typedef enum logic [1:0] {
      UPD_ZERO      = 2'd0,
      UPD_PERIOD    = 2'd1,
      UPD_BOTH      = 2'd2,
      UPD_IMMEDIATE = 2'd3
   } _upd_mode;

endpackage

// File: rtl/pwm_carrier_counter.sv
// Carrier counter: up / down / up-down ramp with phase sync and zero/period strobes.
// Strobes are combinational from the registered count and are gated by the run input.
module carrier_counter
   import PKG_pwm::*;
#(
   parameter int CW = `CARRCOUNT_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  _carr_mode     mode,
   input  logic [CW-1:0] period,
   input  logic          sync,
   input  logic [CW-1:0] init_phase,
   input  logic          init_dir,
   output logic [CW-1:0] carrier,
   output logic          dir,
   output logic          evt_zero,
   output logic          evt_period
);

   logic [CW-1:0] carrier_next;
   logic          dir_next;

   always_comb begin
      carrier_next = carrier;
      dir_next     = dir;
      if (!run) begin
         carrier_next = '0;
         dir_next     = 1'b1;
      end else if (sync) begin
         carrier_next = (init_phase > period) ? period : init_phase;
         dir_next     = init_dir;
      end else if (period == '0) begin
         carrier_next = '0;
         dir_next     = 1'b1;
      end else begin
         case (mode)
            CARR_DOWN: begin
               dir_next     = 1'b0;
               carrier_next = (carrier == '0 || carrier > period) ? period
                                                                  : carrier - CW'(1);
            end
            CARR_UPDOWN: begin
               if (dir) begin
                  // Turn around at the top; an over-range count snaps to the period.
                  if (carrier >= period) begin
                     carrier_next = (carrier == period) ? period - CW'(1) : period;
                     dir_next     = 1'b0;
                  end else begin
                     carrier_next = carrier + CW'(1);
                  end
               end else if (carrier == '0) begin
                  carrier_next = CW'(1);
                  dir_next     = 1'b1;
               end else begin
                  carrier_next = carrier - CW'(1);
               end
            end
            default: begin
               dir_next     = 1'b1;
               carrier_next = (carrier >= period) ? '0 : carrier + CW'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carrier <= '0;
         dir     <= 1'b1;
      end else begin
         carrier <= carrier_next;
         dir     <= dir_next;
      end
   end

   assign evt_zero   = run && (carrier == '0);
   assign evt_period = run && (carrier == period);

endmodule

// File: rtl/pwm_carrier.sv
// One PWM leg: active period/compare/mode registers fed from shadow values at selected
// carrier events, the carrier counter, and a registered carrier < compare comparator.
module pwm_carrier
   import PKG_pwm::*;
#(
   parameter int CW = `CARRCOUNT_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   input  _pwm_onoff     carr_onoff,
   input  _carr_mode     carr_mode,
   input  _upd_mode      upd_mode,
   input  logic [CW-1:0] period,
   input  logic [CW-1:0] compare,
   input  logic [CW-1:0] init_phase,
   input  logic          init_dir,
   input  logic          sync,
   output logic          pwm,
   output logic [CW-1:0] carrier,
   output logic          dir,
   output logic          evt_zero,
   output logic          evt_period
);

   logic [CW-1:0] period_act;
   logic [CW-1:0] compare_act;
   _carr_mode     mode_act;
   logic          on;
   logic          running;
   logic          upd_evt;

   assign on = (carr_onoff == PWM_ON);
   // Strobes stay low while reset is held so every output shows its reset value.
   assign running = on && !reset;

   carrier_counter #(
      .CW(CW)
   ) u_counter (
      .clk        (clk),
      .reset      (reset),
      .run        (running),
      .mode       (mode_act),
      .period     (period_act),
      .sync       (sync),
      .init_phase (init_phase),
      .init_dir   (init_dir),
      .carrier    (carrier),
      .dir        (dir),
      .evt_zero   (evt_zero),
      .evt_period (evt_period)
   );

   always_comb begin
      upd_evt = 1'b0;
      case (upd_mode)
         UPD_ZERO:      upd_evt = evt_zero;
         UPD_PERIOD:    upd_evt = evt_period;
         UPD_BOTH:      upd_evt = evt_zero || evt_period;
         UPD_IMMEDIATE: upd_evt = 1'b1;
         default:       upd_evt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_act  <= '0;
         compare_act <= '0;
         mode_act    <= CARR_UP;
         pwm         <= 1'b0;
      end else if (!on) begin
         period_act  <= period;
         compare_act <= compare;
         mode_act    <= carr_mode;
         pwm         <= 1'b0;
      end else begin
         if (upd_evt) begin
            period_act  <= period;
            compare_act <= compare;
         end
         pwm <= (carrier < compare_act);
      end
   end

endmodule

// File: doc/pwm_carrier.md
# pwm_carrier

Carrier generator and comparator for one PWM leg of the pwm8carr subsystem. It produces the raw `pwm` signal consumed by `dead_time`, plus the carrier value and zero/period event strobes for interleaving and interrupt logic. The register file supplies period and compare values as shadow values. The block latches them into active registers only at configurable carrier events, so duty updates never glitch mid-period.

## Interface
- `CW`, default `` `CARRCOUNT_WIDTH `` (16): carrier counter width.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `carr_onoff`  in  `_pwm_onoff`  PWM_ON runs the carrier; PWM_OFF holds it.
- `carr_mode`  in  `_carr_mode`  CARR_UP, CARR_DOWN or CARR_UPDOWN; latched only while off.
- `upd_mode`  in  `_upd_mode`  UPD_ZERO, UPD_PERIOD, UPD_BOTH or UPD_IMMEDIATE.
- `period`  in  CW  shadow period value.
- `compare`  in  CW  shadow compare value.
- `init_phase`  in  CW  counter value loaded on `sync`.
- `init_dir`  in  1  direction loaded on `sync` (1 = up).
- `sync`  in  1  one-cycle phase-alignment strobe.
- `pwm`  out  1  registered comparator output, feeds `dead_time.pwm`.
- `carrier`  out  CW  current counter value.
- `dir`  out  1  current count direction (1 = up).
- `evt_zero`  out  1  high while `carrier == 0` and running.
- `evt_period`  out  1  high while `carrier == period_act` and running.

## Operation
- Active registers: `period_act`, `compare_act`, `mode_act`.
- Update event: the edge ending a cycle in which the selected event is high.
  - UPD_ZERO uses `evt_zero`; UPD_PERIOD uses `evt_period`; UPD_BOTH uses either.
  - UPD_IMMEDIATE updates every edge.
  - `period_act` and `compare_act` load from `period` and `compare` at each update event.
- Off state (PWM_OFF):
  - `carrier` = 0 and `dir` = 1.
  - Active registers load every edge; `mode_act` ← `carr_mode`.
  - `pwm`, `evt_zero` and `evt_period` are 0.
- CARR_UP: 0,1,…,P,0,… with period P+1 cycles. If `carrier >= P` the next value is 0.
- CARR_DOWN: P,P−1,…,0,P,… with period P+1 cycles. If `carrier > P` the next value is P. Counting starts from 0, so the first step after turn-on reloads P.
- CARR_UPDOWN: 0↑P↓0 with period 2P cycles.
  - `dir` flips to 0 at `carrier == P` and to 1 at `carrier == 0`.
  - If `carrier > P` while counting up, the next value is P and `dir` becomes 0.
- P = 0: `carrier` stays 0, both events are high every cycle, and updates occur every edge.
- `sync` (running only) has priority over counting:
  - `carrier` ← min(`init_phase`, `period_act`) and `dir` ← `init_dir`.
  - A sync does not itself cause an update.
- Comparator: `pwm` ← (`carrier` < `compare_act`), evaluated on the pre-edge values.
  - `compare_act` = 0 gives a constant 0 (0 %).
  - `compare_act` > `period_act` gives a constant 1 (100 %).
- Reset mid-operation returns the block to the reset state immediately. The counter restarts only after reset is released, from 0 with `evt_zero` asserted.

## Timing
- Reset values: `carrier` = 0, `dir` = 1, `pwm` = 0; `period_act`, `compare_act` = 0; `mode_act` = CARR_UP.
- Events are combinational from the registered `carrier` and the on state, with zero latency.
- `pwm` lags `carrier` by exactly 1 cycle.
- A new compare value written before an update event affects `pwm` starting 1 cycle after that event's edge.
- Off→on: in the first on cycle, `carrier` = 0 and `evt_zero` = 1.
- On→off: in the next cycle `carrier` = 0; `pwm` = 0 from that cycle onward.
- `sync` applied at edge k: `carrier` = `init_phase` in cycle k+1, and `pwm` reflects it in k+2.

## Structure
- Add to `PKG_pwm`:
  - `_carr_mode` (2 bits) and `_upd_mode` (2 bits) enums.
  - `` `CARRCOUNT_WIDTH `` macro.
- Reuse the existing `_pwm_onoff` type.
- One sub-module, `carrier_counter`: counter, direction, sync and the event strobes.
- Top level `pwm_carrier` holds the active registers, update selection and comparator.

## Test plan
- UP, P = 9, compare = 3: `pwm` high for exactly 3 of every 10 cycles. `evt_zero` and `evt_period` each pulse once per 10 cycles.
- UPDOWN, P = 4, compare = 2: `carrier` runs 0,1,2,3,4,3,2,1 repeating. `pwm` is high for 3 of every 8 cycles, and `dir` toggles at 4 and 0.
- UPD_ZERO with compare changed 3→7 mid-period: `pwm` keeps the old duty until the wrap, then has duty 7/10 from the cycle after the zero edge.
- compare = 0 gives `pwm` constantly 0; compare = 12 with P = 9 gives `pwm` constantly 1; P = 0 holds `carrier` at 0 with both events high.
- `sync` with init_phase = 5, init_dir = 0 in UPDOWN mode with P = 8: the next `carrier` values are 5,4,3. With init_phase = 20 the `carrier` becomes 8.
- Assert `reset` mid-count (`carrier` = 6): all outputs go to their reset values immediately. After release with PWM_ON, `carrier` = 0 and `evt_zero` = 1 in the first cycle.
